// File: rtl/nbyn_buffered.sv
// Input-buffered torus node: per-input FIFOs with round-robin output registers.
// Optional NOC_STATS_EN adds saturating PE ejection and stall counters.
module nbyn_buffered #(
  parameter int X           = 2,
  parameter int Y           = 2,
  parameter int x_coord     = 0,
  parameter int y_coord     = 0,
  parameter int data_width  = 256,
  parameter int x_size      = 1,
  parameter int y_size      = 1,
  parameter int total_width = x_size + y_size + data_width,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_valid_l,
  input  logic [total_width-1:0] i_data_l,
  output logic                   o_ready_l,
  input  logic                   i_valid_b,
  input  logic [total_width-1:0] i_data_b,
  output logic                   o_ready_b,
  input  logic                   i_valid_pe,
  input  logic [total_width-1:0] i_data_pe,
  output logic                   o_ready_pe,
  output logic                   o_valid_r,
  output logic [total_width-1:0] o_data_r,
  input  logic                   i_ready_r,
  output logic                   o_valid_t,
  output logic [total_width-1:0] o_data_t,
  input  logic                   i_ready_t,
  output logic                   o_valid_pe,
  output logic [total_width-1:0] o_data_pe,
  input  logic                   i_ready_pe
`ifdef NOC_STATS_EN
  ,
  output logic [31:0]            o_eject_cnt,
  output logic [31:0]            o_stall_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [x_size-1:0] XC = x_size'(x_coord % X);
  localparam logic [y_size-1:0] YC = y_size'(y_coord % Y);

  typedef logic [total_width-1:0] flit_t;

  logic [2:0] in_v, full, empty, push, pop;
  logic [2:0] rdy, can_load, ov_q;
  logic [2:0][total_width-1:0] in_d, head;
  logic [2:0][total_width-1:0] od_q, sel_d;
  logic [2:0][2:0] req, gnt;
  logic [2:0][1:0] route, last_q, gidx_d;
  logic [2:0][AW-1:0] wp_q, rp_q;
  logic [2:0][CW-1:0] cnt_q;
  flit_t mem_q [3][FIFO_DEPTH];

  assign in_v = {i_valid_pe, i_valid_b, i_valid_l};
  assign in_d = {i_data_pe, i_data_b, i_data_l};
  assign rdy  = {i_ready_pe, i_ready_t, i_ready_r};

  function automatic logic [2:0] rr(
    input logic [2:0] r,
    input logic [1:0] last
  );
    logic [2:0] g;
    logic hit;
    int idx;
    g   = '0;
    hit = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      idx = (int'(last) + i) % 3;
      if (!hit && r[idx]) begin
        g[idx] = 1'b1;
        hit    = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    full     = '0;
    empty    = '0;
    push     = '0;
    pop      = '0;
    head     = '0;
    route    = '0;
    req      = '0;
    gnt      = '0;
    can_load = '0;
    sel_d    = '0;
    gidx_d   = '0;
    for (int k = 0; k < 3; k++) begin
      full[k]  = cnt_q[k] == CW'(FIFO_DEPTH);
      empty[k] = cnt_q[k] == '0;
      push[k]  = in_v[k] & ~full[k];
      head[k]  = mem_q[k][rp_q[k]];
      // Dimension-ordered: resolve X before Y.
      if (head[k][data_width +: x_size] != XC)
        route[k] = 2'd0;
      else if (head[k][total_width-1 -: y_size] != YC)
        route[k] = 2'd1;
      else
        route[k] = 2'd2;
    end
    for (int o = 0; o < 3; o++) begin
      can_load[o] = ~ov_q[o] | rdy[o];
      for (int k = 0; k < 3; k++)
        req[o][k] = ~empty[k] & (route[k] == 2'(o));
      if (can_load[o])
        gnt[o] = rr(req[o], last_q[o]);
      for (int k = 0; k < 3; k++) begin
        if (gnt[o][k]) begin
          sel_d[o]  = head[k];
          gidx_d[o] = 2'(k);
          pop[k]    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 3; k++)
      if (push[k])
        mem_q[k][wp_q[k]] <= in_d[k];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ov_q   <= '0;
      od_q   <= '0;
      last_q <= {3{2'd2}};
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (push[k])
          wp_q[k] <= wp_q[k] + 1'b1;
        if (pop[k])
          rp_q[k] <= rp_q[k] + 1'b1;
        cnt_q[k] <= cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      end
      for (int o = 0; o < 3; o++) begin
        if (|gnt[o]) begin
          ov_q[o]   <= 1'b1;
          od_q[o]   <= sel_d[o];
          last_q[o] <= gidx_d[o];
        end else if (rdy[o]) begin
          ov_q[o] <= 1'b0;
        end
      end
    end
  end

  assign o_ready_l  = ~full[0];
  assign o_ready_b  = ~full[1];
  assign o_ready_pe = ~full[2];
  assign o_valid_r  = ov_q[0];
  assign o_valid_t  = ov_q[1];
  assign o_valid_pe = ov_q[2];
  assign o_data_r   = od_q[0];
  assign o_data_t   = od_q[1];
  assign o_data_pe  = od_q[2];

`ifdef NOC_STATS_EN
  logic [31:0] ej_q, st_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ej_q <= '0;
      st_q <= '0;
    end else begin
      if (ov_q[2] && rdy[2] && ej_q != '1)
        ej_q <= ej_q + 32'd1;
      if (|(ov_q & ~rdy) && st_q != '1)
        st_q <= st_q + 32'd1;
    end
  end

  assign o_eject_cnt = ej_q;
  assign o_stall_cnt = st_q;
`endif

endmodule
